controle_bombas: RTL and testbench



---
 rtl/friscv_pkg.sv | 24 ++
 rtl/gerador_pwm_rampa.sv | 50 +++++
 rtl/controle_bombas.sv | 166 ++++++++++++++++
 tb/tb_controle_bombas.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_pkg.sv
// Shared Frisc-V pump-dosing types: FSM state codes, pump select, PWM helper.
package friscv_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        ESPERA  = 4'h1,
        RAMPA   = 4'h2,
        DOSANDO = 4'h3,
        PAUSA   = 4'h4,
        FIM     = 4'h5,
        ERRO    = 4'hE
    } estado_t;

    typedef enum logic {
        SEL_BOMBA_1 = 1'b0,
        SEL_BOMBA_2 = 1'b1
    } sel_t;

    // Duty threshold for a ramp step: passo*periodo/passos, integer division.
    function automatic int limiar_pwm(int passo, int periodo, int passos);
        return (passo * periodo) / passos;
    endfunction

endpackage

// File: rtl/gerador_pwm_rampa.sv
// Soft-start PWM ramp: period counter, step counter, duty compare and flags.
module gerador_pwm_rampa
    import friscv_pkg::*;
#(
    parameter int PWM_PERIODO  = 50000,
    parameter int RAMPA_PASSOS = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_reinicia,
    input  logic i_avanca,
    output logic o_duty,
    output logic o_wrap,
    output logic o_fim_rampa
);

    localparam int PW = $clog2(PWM_PERIODO + 1);
    localparam int SW = $clog2(RAMPA_PASSOS + 1);

    logic [PW-1:0] r_pwm_cnt;
    logic [SW-1:0] r_passo;
    logic          w_wrap;
    int            w_limiar;

    assign w_wrap      = (r_pwm_cnt == PW'(PWM_PERIODO - 1));
    assign w_limiar    = limiar_pwm(int'(r_passo), PWM_PERIODO, RAMPA_PASSOS);
    assign o_duty      = (int'(r_pwm_cnt) < w_limiar);
    assign o_wrap      = w_wrap;
    assign o_fim_rampa = w_wrap && (r_passo == SW'(RAMPA_PASSOS));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_passo   <= '0;
        end else if (i_reinicia) begin
            r_pwm_cnt <= '0;
            r_passo   <= SW'(1);
        end else if (i_avanca) begin
            if (w_wrap) begin
                r_pwm_cnt <= '0;
                // Step saturates at the last ramp step.
                if (r_passo != SW'(RAMPA_PASSOS))
                    r_passo <= r_passo + SW'(1);
            end else begin
                r_pwm_cnt <= r_pwm_cnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/controle_bombas.sv
// Pump dosing FSM: PWM soft start, timed dose, cup pause/timeout, done pulse.
// Optional FRISCV_BOMBA_CONTADOR_EN adds per-pump completed-dose counters.
module controle_bombas
    import friscv_pkg::*;
#(
    parameter int DOSE_CICLOS    = 150000000,
    parameter int PWM_PERIODO    = 50000,
    parameter int RAMPA_PASSOS   = 8,
    parameter int TIMEOUT_CICLOS = 250000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ativa_bomba_1,
    input  logic       ativa_bomba_2,
    input  logic       copo_posicionado,
    output logic       bomba_1,
    output logic       bomba_2,
    output logic       fim_dosagem,
    output logic       erro,
    output logic [3:0] db_estado
`ifdef FRISCV_BOMBA_CONTADOR_EN
    ,
    output logic [7:0] db_doses_1,
    output logic [7:0] db_doses_2
`endif
);

    localparam int DW = $clog2(DOSE_CICLOS + 1);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

    estado_t       r_estado;
    estado_t       w_prox;
    sel_t          r_sel;
    logic [DW-1:0] r_dose_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_fim;

    logic w_req_sel;
    logic w_dose_fim;
    logic w_to_fim;
    logic w_partida;
    logic w_retoma;
    logic w_conta_dose;
    logic w_entra_fim;
    logic w_duty;
    logic w_wrap;
    logic w_fim_rampa;
    logic w_ativa;

    assign w_req_sel   = (r_sel == SEL_BOMBA_2) ? ativa_bomba_2 : ativa_bomba_1;
    assign w_dose_fim  = (r_dose_cnt == DW'(DOSE_CICLOS - 1));
    assign w_to_fim    = (r_to_cnt == TW'(TIMEOUT_CICLOS - 1));
    assign w_entra_fim = (w_prox == FIM) && (r_estado != FIM);

    gerador_pwm_rampa #(
        .PWM_PERIODO (PWM_PERIODO),
        .RAMPA_PASSOS(RAMPA_PASSOS)
    ) u_pwm (
        .clock      (clock),
        .reset      (reset),
        .i_reinicia (w_partida || w_retoma),
        .i_avanca   (r_estado == RAMPA),
        .o_duty     (w_duty),
        .o_wrap     (w_wrap),
        .o_fim_rampa(w_fim_rampa)
    );

    always_comb begin
        w_prox       = r_estado;
        w_partida    = 1'b0;
        w_retoma     = 1'b0;
        w_conta_dose = 1'b0;
        unique case (r_estado)
            INICIAL: w_prox = ESPERA;
            ESPERA: begin
                if ((ativa_bomba_1 || ativa_bomba_2) && copo_posicionado) begin
                    w_prox    = RAMPA;
                    w_partida = 1'b1;
                end
            end
            RAMPA, DOSANDO: begin
                if (!w_req_sel)
                    w_prox = ESPERA;
                else if (!copo_posicionado)
                    w_prox = PAUSA;
                else if (w_dose_fim)
                    w_prox = FIM;
                else begin
                    w_conta_dose = 1'b1;
                    if (r_estado == RAMPA && w_fim_rampa)
                        w_prox = DOSANDO;
                end
            end
            PAUSA: begin
                if (!w_req_sel)
                    w_prox = ESPERA;
                else if (w_to_fim)
                    w_prox = ERRO;
                else if (copo_posicionado) begin
                    w_prox   = RAMPA;
                    w_retoma = 1'b1;
                end
            end
            FIM: begin
                if (!w_req_sel)
                    w_prox = ESPERA;
            end
            ERRO: w_prox = ERRO;
            default: w_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_sel      <= SEL_BOMBA_1;
            r_dose_cnt <= '0;
            r_to_cnt   <= '0;
            r_fim      <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_fim    <= w_entra_fim;
            if (w_partida) begin
                r_sel      <= ativa_bomba_1 ? SEL_BOMBA_1 : SEL_BOMBA_2;
                r_dose_cnt <= '0;
            end else if (w_conta_dose) begin
                r_dose_cnt <= r_dose_cnt + DW'(1);
            end
            if (w_prox == PAUSA && r_estado != PAUSA)
                r_to_cnt <= '0;
            else if (r_estado == PAUSA && !w_to_fim)
                r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

`ifdef FRISCV_BOMBA_CONTADOR_EN
    logic [7:0] r_doses_1;
    logic [7:0] r_doses_2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_doses_1 <= '0;
            r_doses_2 <= '0;
        end else if (w_entra_fim) begin
            if (r_sel == SEL_BOMBA_1 && r_doses_1 != 8'hFF)
                r_doses_1 <= r_doses_1 + 8'd1;
            if (r_sel == SEL_BOMBA_2 && r_doses_2 != 8'hFF)
                r_doses_2 <= r_doses_2 + 8'd1;
        end
    end

    assign db_doses_1 = r_doses_1;
    assign db_doses_2 = r_doses_2;
`endif

    // Cup gating is combinational so the pump drops in the removal cycle.
    assign w_ativa = copo_posicionado
                   && ((r_estado == RAMPA && w_duty) || r_estado == DOSANDO);

    assign bomba_1     = w_ativa && (r_sel == SEL_BOMBA_1);
    assign bomba_2     = w_ativa && (r_sel == SEL_BOMBA_2);
    assign fim_dosagem = r_fim;
    assign erro        = (r_estado == ERRO);
    assign db_estado   = r_estado;

endmodule

// File: tb/tb_controle_bombas.sv
// Scoreboard bench for controle_bombas with small dose/PWM/timeout parameters.
module tb_controle_bombas;

    localparam int DOSE = 100;
    localparam int PER  = 8;
    localparam int PAS  = 4;
    localparam int TO   = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a1 = 1'b0;
    logic       a2 = 1'b0;
    logic       copo = 1'b0;
    logic       bomba_1;
    logic       bomba_2;
    logic       fim_dosagem;
    logic       erro;
    logic [3:0] db_estado;
`ifdef FRISCV_BOMBA_CONTADOR_EN
    logic [7:0] db_doses_1;
    logic [7:0] db_doses_2;
`endif

    always #5 clock = ~clock;

    controle_bombas #(
        .DOSE_CICLOS   (DOSE),
        .PWM_PERIODO   (PER),
        .RAMPA_PASSOS  (PAS),
        .TIMEOUT_CICLOS(TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ativa_bomba_1   (a1),
        .ativa_bomba_2   (a2),
        .copo_posicionado(copo),
        .bomba_1         (bomba_1),
        .bomba_2         (bomba_2),
        .fim_dosagem     (fim_dosagem),
        .erro            (erro),
        .db_estado       (db_estado)
`ifdef FRISCV_BOMBA_CONTADOR_EN
        ,
        .db_doses_1      (db_doses_1),
        .db_doses_2      (db_doses_2)
`endif
    );

    typedef struct {
        int ciclo;
        int bomba;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ultima   = 0;

    always @(posedge clock) cyc++;

    task automatic chk(string nome, int atual, int esperado);
        checks++;
        if (atual != esperado) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nome, atual, esperado, cyc);
        end
    endtask

    // Monitor: pops the expected completion whenever a done pulse appears.
    always @(negedge clock) begin
        exp_t e;
        if (bomba_1 && bomba_2)
            chk("exclusive_pumps", 1, 0);
        if (bomba_1)
            ultima = 1;
        else if (bomba_2)
            ultima = 2;
        if (fim_dosagem) begin
            if (q.size() == 0) begin
                chk("unexpected_fim", cyc, -1);
            end else begin
                e = q.pop_front();
                chk("fim_cycle", cyc, e.ciclo);
                chk("fim_pump", ultima, e.bomba);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic ate(int alvo);
        while (cyc < alvo) tick();
    endtask

    // Full pump-1 dose starting from ESPERA; ends back in ESPERA.
    task automatic dose1();
        int s;
        a1   = 1'b1;
        copo = 1'b1;
        s    = cyc;
        q.push_back('{s + DOSE + 1, 1});
        ate(s + DOSE + 2);
        chk("fim_hold_state", int'(db_estado), 5);
        a1 = 1'b0;
        tick();
        chk("fim_exit_state", int'(db_estado), 1);
    endtask

    // Pump-2 dose dropped at dose cycle 40; no completion expected.
    task automatic aborta2();
        int s;
        a2   = 1'b1;
        copo = 1'b1;
        s    = cyc;
        ate(s + 41);
        chk("abort_before_b2", int'(bomba_2), 1);
        a2 = 1'b0;
        tick();
        chk("abort_b2_off", int'(bomba_2), 0);
        chk("abort_state", int'(db_estado), 1);
        repeat (5) tick();
    endtask

    initial begin
        int s;
        int k;
        // Reset state
        tick();
        tick();
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_b1", int'(bomba_1), 0);
        chk("rst_b2", int'(bomba_2), 0);
        chk("rst_fim", int'(fim_dosagem), 0);
        chk("rst_erro", int'(erro), 0);
        reset = 1'b0;
        tick();
        chk("espera_after_init", int'(db_estado), 1);

        // Request without cup stays in ESPERA
        a1 = 1'b1;
        tick();
        tick();
        chk("no_cup_wait", int'(db_estado), 1);
        a1 = 1'b0;
        tick();

        // Test 1: pump-1 dose with ramp pattern 2/8, 4/8, 6/8, 8/8
        a1   = 1'b1;
        copo = 1'b1;
        s    = cyc;
        q.push_back('{s + DOSE + 1, 1});
        for (int i = 0; i < 4 * PER; i++) begin
            tick();
            k = i % PER;
            chk("ramp_b1", int'(bomba_1), (k < 2 * (i / PER + 1)) ? 1 : 0);
            chk("ramp_b2", int'(bomba_2), 0);
        end
        tick();
        chk("dosando_at_32", int'(db_estado), 3);
        chk("dosando_b1", int'(bomba_1), 1);
        ate(s + DOSE);
        chk("last_pump_cycle", int'(bomba_1), 1);
        ate(s + DOSE + 3);
        chk("fim_held", int'(db_estado), 5);
        chk("fim_single", int'(fim_dosagem), 0);
        a1 = 1'b0;
        tick();
        chk("t1_back_espera", int'(db_estado), 1);

        // Test 2: both requests rise together; pump 1 wins, then pump 2
        a1 = 1'b1;
        a2 = 1'b1;
        s  = cyc;
        q.push_back('{s + DOSE + 1, 1});
        tick();
        chk("tie_b1", int'(bomba_1), 1);
        chk("tie_b2", int'(bomba_2), 0);
        ate(s + DOSE + 2);
        a1 = 1'b0;
        tick();
        chk("t2_espera", int'(db_estado), 1);
        s = cyc;
        q.push_back('{s + DOSE + 1, 2});
        tick();
        chk("p2_b2", int'(bomba_2), 1);
        chk("p2_b1", int'(bomba_1), 0);
        ate(s + DOSE + 2);
        a2 = 1'b0;
        tick();
        chk("t2b_espera", int'(db_estado), 1);

        // Test 3: cup removed at dose cycle 60 for 20 cycles
        a1 = 1'b1;
        s  = cyc;
        q.push_back('{s + 61 + 20 + 1 + (DOSE - 60), 1});
        ate(s + 61);
        copo = 1'b0;
        #1;
        chk("gap_b1_same_cycle", int'(bomba_1), 0);
        ate(s + 70);
        chk("gap_pausa", int'(db_estado), 4);
        chk("gap_b1", int'(bomba_1), 0);
        ate(s + 81);
        copo = 1'b1;
        tick();
        chk("resume_rampa", int'(db_estado), 2);
        chk("resume_b1_on", int'(bomba_1), 1);
        tick();
        tick();
        chk("resume_ramp_restart", int'(bomba_1), 0);
        ate(s + 123);
        a1 = 1'b0;
        tick();
        chk("t3_espera", int'(db_estado), 1);
`ifdef FRISCV_BOMBA_CONTADOR_EN
        chk("doses1_mid", int'(db_doses_1), 3);
        chk("doses2_mid", int'(db_doses_2), 1);
`endif

        // Test 4: cup gone for 50 cycles -> ERRO until reset
        a1 = 1'b1;
        s  = cyc;
        ate(s + 11);
        copo = 1'b0;
        ate(s + 61);
        copo = 1'b1;
        tick();
        chk("erro_flag", int'(erro), 1);
        chk("erro_state", int'(db_estado), 14);
        repeat (5) tick();
        chk("erro_sticky", int'(erro), 1);
        chk("erro_b1_off", int'(bomba_1), 0);
        a1    = 1'b0;
        reset = 1'b1;
        tick();
        chk("erro_rst_flag", int'(erro), 0);
        chk("erro_rst_state", int'(db_estado), 0);
`ifdef FRISCV_BOMBA_CONTADOR_EN
        chk("doses1_rst", int'(db_doses_1), 0);
        chk("doses2_rst", int'(db_doses_2), 0);
`endif
        reset = 1'b0;
        tick();
        chk("erro_rst_espera", int'(db_estado), 1);

        // Test 5: pump 2 request dropped at cycle 40
        aborta2();

        // Reset in the middle of a dose
        a1 = 1'b1;
        s  = cyc;
        ate(s + 20);
        chk("mid_b1_on", int'(bomba_1), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_b1", int'(bomba_1), 0);
        chk("mid_rst_state", int'(db_estado), 0);
        chk("mid_rst_fim", int'(fim_dosagem), 0);
        a1    = 1'b0;
        reset = 1'b0;
        tick();
        chk("mid_rst_espera", int'(db_estado), 1);

        // Three pump-1 doses plus one aborted dose
        dose1();
        dose1();
        dose1();
        aborta2();
`ifdef FRISCV_BOMBA_CONTADOR_EN
        chk("doses1_final", int'(db_doses_1), 3);
        chk("doses2_final", int'(db_doses_2), 0);
`endif

        repeat (5) tick();
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
